// File: rtl/count_sequencer.sv
// count_sequencer
//   Run controller for the WIDTH-bit wrap/stop counter. A start command
//   captures a load value, step, direction, run length and boundary mode,
//   then the count is sequenced through LOAD -> RUN -> DONE. Boundary
//   crossings are reported on a sticky-per-run overflow flag. In stop mode a
//   crossing saturates the count and ends the run early. In wrap mode the
//   count rolls over modulo 2^WIDTH and the run continues.

module count_sequencer #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              iClk,
  input  logic              _iReset,
  input  logic              iStart,
  input  logic [WIDTH-1:0]  iLoadVal,
  input  logic [STEP_W-1:0] iStep,
  input  logic              iUp,
  input  logic              _iWrapstop,
  input  logic [WIDTH-1:0]  iRunLen,
  input  logic              iAbort,
  output logic [WIDTH-1:0]  oCount,
  output logic              oBusy,
  output logic              oDone,
  output logic              oOverflow,
  output logic [1:0]        oState
);

  // Encodings are visible on oState, so they are fixed explicitly.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } stateT;

  localparam logic [WIDTH-1:0] lastStep = WIDTH'(1);
  localparam logic [WIDTH-1:0] countMax = '1;
  localparam logic [WIDTH-1:0] countMin = '0;

  stateT             state;
  logic [WIDTH-1:0]  remaining;

  // Configuration captured on the accepted start edge.
  logic [WIDTH-1:0]  cfgLoadVal;
  logic [STEP_W-1:0] cfgStep;
  logic              cfgUp;
  logic              cfgStop;
  logic [WIDTH-1:0]  cfgRunLen;

  // One-step datapath, evaluated every cycle but only used in RUN.
  logic [WIDTH:0]    stepExt;
  logic [WIDTH:0]    upSum;
  logic [WIDTH:0]    downDiff;
  logic              crossed;
  logic [WIDTH-1:0]  wrapped;
  logic [WIDTH-1:0]  steppedCount;
  logic              stopNow;

  // Compute the next count for a RUN step at WIDTH+1 bits so the carry
  // (up) or borrow (down) bit flags a boundary crossing directly.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no
    // path leaves a value unassigned and no latch is inferred.
    stepExt      = '0;
    upSum        = '0;
    downDiff     = '0;
    crossed      = 1'b0;
    wrapped      = '0;
    steppedCount = '0;
    stopNow      = 1'b0;

    stepExt  = {{(WIDTH + 1 - STEP_W){1'b0}}, cfgStep};
    upSum    = {1'b0, oCount} + stepExt;
    downDiff = {1'b0, oCount} - stepExt;

    // Landing exactly on 0 or countMax leaves the top bit clear, so only a
    // real crossing raises it.
    if (cfgUp) begin
      crossed = upSum[WIDTH];
      wrapped = upSum[WIDTH-1:0];
    end else begin
      crossed = downDiff[WIDTH];
      wrapped = downDiff[WIDTH-1:0];
    end

    stopNow = crossed && cfgStop;

    if (stopNow) begin
      steppedCount = cfgUp ? countMax : countMin;
    end else begin
      steppedCount = wrapped;
    end
  end

  // Sequencer: state, count, overflow, done pulse and captured config.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the reset is asynchronous and clears every register, including
  // the captured config, so oCount/oState are at reset values immediately.
  always_ff @(posedge iClk or negedge _iReset) begin
    if (!_iReset) begin
      state      <= IDLE;
      oCount     <= '0;
      oOverflow  <= 1'b0;
      oDone      <= 1'b0;
      remaining  <= '0;
      cfgLoadVal <= '0;
      cfgStep    <= '0;
      cfgUp      <= 1'b0;
      cfgStop    <= 1'b0;
      cfgRunLen  <= '0;
    end else begin
      case (state)
        IDLE: begin
          oDone <= 1'b0;
          // iAbort has no meaning here; only iStart is looked at.
          if (iStart) begin
            cfgLoadVal <= iLoadVal;
            cfgStep    <= iStep;
            cfgUp      <= iUp;
            cfgStop    <= _iWrapstop;
            cfgRunLen  <= iRunLen;
            state      <= LOAD;
          end
        end

        LOAD: begin
          if (iAbort) begin
            // Abandon before loading: count and overflow keep old values.
            oDone <= 1'b0;
            state <= IDLE;
          end else begin
            oCount    <= cfgLoadVal;
            remaining <= cfgRunLen;
            oOverflow <= 1'b0;
            if (cfgRunLen == '0) begin
              oDone <= 1'b1;
              state <= DONE;
            end else begin
              oDone <= 1'b0;
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (iAbort) begin
            // Abort wins over both the step and the final DONE transition.
            oDone <= 1'b0;
            state <= IDLE;
          end else begin
            oCount    <= steppedCount;
            remaining <= remaining - lastStep;
            if (crossed) begin
              oOverflow <= 1'b1;
            end
            if (stopNow || (remaining == lastStep)) begin
              oDone <= 1'b1;
              state <= DONE;
            end else begin
              oDone <= 1'b0;
            end
          end
        end

        DONE: begin
          // Single-cycle completion; iStart and iAbort are ignored here.
          oDone <= 1'b0;
          state <= IDLE;
        end

        default: begin
          oDone <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decodes straight from the state register.
  assign oBusy  = (state != IDLE);
  assign oState = state;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer
//   Directed scenarios for count_sequencer. Each cycle's expected outputs are
//   pushed to a scoreboard before the clock edge that produces them and are
//   popped and compared one time unit after that edge.

module tb_count_sequencer;

  localparam logic [1:0] sIdle = 2'b00;
  localparam logic [1:0] sLoad = 2'b01;
  localparam logic [1:0] sRun  = 2'b10;
  localparam logic [1:0] sDone = 2'b11;

  logic       iClk;
  logic       _iReset;
  logic       iStart;
  logic [7:0] iLoadVal;
  logic [3:0] iStep;
  logic       iUp;
  logic       _iWrapstop;
  logic [7:0] iRunLen;
  logic       iAbort;
  logic [7:0] oCount;
  logic       oBusy;
  logic       oDone;
  logic       oOverflow;
  logic [1:0] oState;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] count;
    logic       ovf;
    logic       done;
    logic [1:0] state;
  } expT;

  expT sb[$];

  count_sequencer #(.WIDTH(8), .STEP_W(4)) dut (
    .iClk       (iClk),
    ._iReset    (_iReset),
    .iStart     (iStart),
    .iLoadVal   (iLoadVal),
    .iStep      (iStep),
    .iUp        (iUp),
    ._iWrapstop (_iWrapstop),
    .iRunLen    (iRunLen),
    .iAbort     (iAbort),
    .oCount     (oCount),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oOverflow  (oOverflow),
    .oState     (oState)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkNow(input string tag, input logic [7:0] c, input logic o,
                          input logic d, input logic [1:0] s);
    check({tag, ".count"}, 32'(oCount), 32'(c));
    check({tag, ".ovf"},   32'(oOverflow), 32'(o));
    check({tag, ".done"},  32'(oDone), 32'(d));
    check({tag, ".state"}, 32'(oState), 32'(s));
    check({tag, ".busy"},  32'(oBusy), 32'(s != sIdle));
  endtask

  task automatic expectNext(input string tag, input logic [7:0] c, input logic o,
                            input logic d, input logic [1:0] s);
    expT e;
    e.tag   = tag;
    e.count = c;
    e.ovf   = o;
    e.done  = d;
    e.state = s;
    sb.push_back(e);
  endtask

  task automatic tick();
    expT e;
    @(posedge iClk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard.underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checkNow(e.tag, e.count, e.ovf, e.done, e.state);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] c, input logic o,
                      input logic d, input logic [1:0] s);
    expectNext(tag, c, o, d, s);
    tick();
  endtask

  // Config inputs are don't-care outside the start edge; keep them moving.
  task automatic scrambleCfg();
    iLoadVal   = 8'($urandom);
    iStep      = 4'($urandom);
    iUp        = 1'($urandom);
    _iWrapstop = 1'($urandom);
    iRunLen    = 8'($urandom);
  endtask

  task automatic runStart(input string tag, input logic [7:0] lv, input logic [3:0] st,
                          input logic up, input logic stop, input logic [7:0] len,
                          input logic [7:0] prevCount, input logic prevOvf);
    iStart     = 1'b1;
    iLoadVal   = lv;
    iStep      = st;
    iUp        = up;
    _iWrapstop = stop;
    iRunLen    = len;
    step({tag, ".load"}, prevCount, prevOvf, 1'b0, sLoad);
    iStart = 1'b0;
    scrambleCfg();
  endtask

  initial begin
    _iReset    = 1'b0;
    iStart     = 1'b0;
    iAbort     = 1'b0;
    iLoadVal   = 8'd0;
    iStep      = 4'd0;
    iUp        = 1'b0;
    _iWrapstop = 1'b0;
    iRunLen    = 8'd0;

    // Reset values before any clock edge.
    #2;
    checkNow("reset", 8'd0, 1'b0, 1'b0, sIdle);
    #10;
    _iReset = 1'b1;
    step("idle", 8'd0, 1'b0, 1'b0, sIdle);

    // 1: up, wrap mode, crossing at 253+3.
    runStart("t1", 8'd250, 4'd3, 1'b1, 1'b0, 8'd3, 8'd0, 1'b0);
    step("t1.s0",   8'd250, 1'b0, 1'b0, sRun);
    step("t1.s1",   8'd253, 1'b0, 1'b0, sRun);
    step("t1.s2",   8'd0,   1'b1, 1'b0, sRun);
    step("t1.s3",   8'd3,   1'b1, 1'b1, sDone);
    step("t1.idle", 8'd3,   1'b1, 1'b0, sIdle);

    // 2: up, stop mode saturates at 255 and ends after 2 steps.
    runStart("t2", 8'd250, 4'd3, 1'b1, 1'b1, 8'd5, 8'd3, 1'b1);
    step("t2.s0",   8'd250, 1'b0, 1'b0, sRun);
    step("t2.s1",   8'd253, 1'b0, 1'b0, sRun);
    step("t2.s2",   8'd255, 1'b1, 1'b1, sDone);
    step("t2.idle", 8'd255, 1'b1, 1'b0, sIdle);

    // 3a: down, stop mode saturates at 0.
    runStart("t3a", 8'd2, 4'd4, 1'b0, 1'b1, 8'd4, 8'd255, 1'b1);
    step("t3a.s0",   8'd2, 1'b0, 1'b0, sRun);
    step("t3a.s1",   8'd0, 1'b1, 1'b1, sDone);
    step("t3a.idle", 8'd0, 1'b1, 1'b0, sIdle);

    // 3b: landing exactly on 0 is not overflow.
    runStart("t3b", 8'd4, 4'd4, 1'b0, 1'b1, 8'd1, 8'd0, 1'b1);
    step("t3b.s0",   8'd4, 1'b0, 1'b0, sRun);
    step("t3b.s1",   8'd0, 1'b0, 1'b1, sDone);
    step("t3b.idle", 8'd0, 1'b0, 1'b0, sIdle);

    // 3c: landing exactly on 255 is not overflow.
    runStart("t3c", 8'd252, 4'd3, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0);
    step("t3c.s0",   8'd252, 1'b0, 1'b0, sRun);
    step("t3c.s1",   8'd255, 1'b0, 1'b1, sDone);
    step("t3c.idle", 8'd255, 1'b0, 1'b0, sIdle);

    // 3d: down, wrap mode: 3-5 -> 254, then 249.
    runStart("t3d", 8'd3, 4'd5, 1'b0, 1'b0, 8'd2, 8'd255, 1'b0);
    step("t3d.s0",   8'd3,   1'b0, 1'b0, sRun);
    step("t3d.s1",   8'd254, 1'b1, 1'b0, sRun);
    step("t3d.s2",   8'd249, 1'b1, 1'b1, sDone);
    step("t3d.idle", 8'd249, 1'b1, 1'b0, sIdle);

    // 3e: step 0 holds the count for the whole run.
    runStart("t3e", 8'd9, 4'd0, 1'b1, 1'b1, 8'd2, 8'd249, 1'b1);
    step("t3e.s0",   8'd9, 1'b0, 1'b0, sRun);
    step("t3e.s1",   8'd9, 1'b0, 1'b0, sRun);
    step("t3e.s2",   8'd9, 1'b0, 1'b1, sDone);
    step("t3e.idle", 8'd9, 1'b0, 1'b0, sIdle);

    // 4: run length 0, iStart held through LOAD and DONE starts nothing.
    iStart     = 1'b1;
    iLoadVal   = 8'd77;
    iStep      = 4'd5;
    iUp        = 1'b1;
    _iWrapstop = 1'b0;
    iRunLen    = 8'd0;
    step("t4.load", 8'd9, 1'b0, 1'b0, sLoad);
    scrambleCfg();
    step("t4.done", 8'd77, 1'b0, 1'b1, sDone);
    step("t4.idle", 8'd77, 1'b0, 1'b0, sIdle);
    iStart = 1'b0;
    step("t4.idle2", 8'd77, 1'b0, 1'b0, sIdle);

    // 5: abort on the 3rd RUN cycle; count stays 12, no done.
    runStart("t5", 8'd10, 4'd1, 1'b1, 1'b0, 8'd8, 8'd77, 1'b0);
    step("t5.s0", 8'd10, 1'b0, 1'b0, sRun);
    step("t5.s1", 8'd11, 1'b0, 1'b0, sRun);
    step("t5.s2", 8'd12, 1'b0, 1'b0, sRun);
    iAbort = 1'b1;
    step("t5.abort", 8'd12, 1'b0, 1'b0, sIdle);
    iAbort = 1'b0;
    step("t5.idle", 8'd12, 1'b0, 1'b0, sIdle);

    // 5b: abort ignored in IDLE, honoured in LOAD before the load happens.
    iAbort     = 1'b1;
    iStart     = 1'b1;
    iLoadVal   = 8'd200;
    iStep      = 4'd1;
    iUp        = 1'b1;
    _iWrapstop = 1'b0;
    iRunLen    = 8'd5;
    step("t5b.load", 8'd12, 1'b0, 1'b0, sLoad);
    iStart = 1'b0;
    step("t5b.abort", 8'd12, 1'b0, 1'b0, sIdle);
    iAbort = 1'b0;
    step("t5b.idle", 8'd12, 1'b0, 1'b0, sIdle);

    // 6: asynchronous reset mid-RUN, between edges.
    runStart("t6", 8'd254, 4'd2, 1'b1, 1'b0, 8'd10, 8'd12, 1'b0);
    step("t6.s0", 8'd254, 1'b0, 1'b0, sRun);
    step("t6.s1", 8'd0,   1'b1, 1'b0, sRun);
    #2;
    _iReset = 1'b0;
    #1;
    checkNow("t6.reset", 8'd0, 1'b0, 1'b0, sIdle);
    @(posedge iClk);
    #2;
    checkNow("t6.held", 8'd0, 1'b0, 1'b0, sIdle);
    _iReset = 1'b1;

    // A fresh run after reset behaves normally.
    runStart("t6b", 8'd5, 4'd1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    step("t6b.s0",   8'd5, 1'b0, 1'b0, sRun);
    step("t6b.s1",   8'd4, 1'b0, 1'b1, sDone);
    step("t6b.idle", 8'd4, 1'b0, 1'b0, sIdle);

    check("scoreboard.empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
